panel_stream_receiver: RTL and testbench

PANEL_STREAM_RECEIVER -- requirements
Module: panel_stream_receiver

---
 rtl/cube_pkg.sv | 37 +++
 rtl/sync_edge.sv | 37 +++
 rtl/panel_stream_receiver.sv | 166 ++++++++++++++++
 tb/tb_panel_stream_receiver.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cube_pkg.sv
// Shared definitions for the panel stream receiver: default geometry,
// row-select sizing, receiver FSM states and row-select decode helpers.
package cube_pkg;

  localparam int LANES_DEFAULT = 12;
  localparam int BITS_DEFAULT  = 16;
  localparam int ROW_COUNT     = 16;
  localparam int ROW_IDX_W     = 4;
  localparam int ROW_CNT_W     = $clog2(ROW_COUNT + 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SHIFTING = 2'd1,
    ST_OVERRUN  = 2'd2
  } rx_state_t;

  // Index of the lowest-numbered asserted (low) row select, 0 if none.
  function automatic logic [ROW_IDX_W-1:0] lowest_active(input logic [ROW_COUNT-1:0] sel_n);
    logic [ROW_IDX_W-1:0] idx;
    idx = '0;
    for (int i = ROW_COUNT - 1; i >= 0; i--) begin
      if (!sel_n[i]) idx = ROW_IDX_W'(i);
    end
    return idx;
  endfunction

  // Number of asserted (low) row selects.
  function automatic logic [ROW_CNT_W-1:0] active_count(input logic [ROW_COUNT-1:0] sel_n);
    logic [ROW_CNT_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < ROW_COUNT; i++) begin
      cnt = cnt + {{(ROW_CNT_W-1){1'b0}}, ~sel_n[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer with rising-edge detect for asynchronous panel
// control inputs. RESET_VAL is the idle level of the input so that reset
// release never manufactures an edge.
module sync_edge
  import cube_pkg::*;
#(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_sync,
  output logic [WIDTH-1:0] o_rise
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;
  logic [WIDTH-1:0] r_prev;

  // Synchronizer chain plus one history flop for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
      r_prev <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_sync = r_sync;
  assign o_rise = r_sync & ~r_prev;

endmodule

// File: rtl/panel_stream_receiver.sv
// Panel stream receiver: samples LANES serial data lanes on an asynchronous
// shift clock, and on each latch strobe presents the captured row together
// with its decoded row number and error flags.
// Optional build macro ROW_CHECK_EN: flag latches whose row select is not
// exactly one-hot (row_index forced to 0 in that case).
module panel_stream_receiver
  import cube_pkg::*;
#(
  parameter int LANES = LANES_DEFAULT,
  parameter int BITS  = BITS_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   serial_clk,
  input  logic                   latch_enable,
  input  logic                   output_enable_n,
  input  logic [LANES-1:0]       serial_data_in,
  input  logic [ROW_COUNT-1:0]   row_select_n,
  output logic [LANES*BITS-1:0]  row_data,
  output logic [ROW_IDX_W-1:0]   row_index,
  output logic                   row_valid,
  output logic                   length_error,
  output logic                   row_error,
  output logic                   blank
);

  localparam int CNT_W = $clog2(BITS + 2);

  // Saturating shift counter step: stops at BITS+1 to mark overrun.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    if (c >= CNT_W'(BITS + 1)) return c;
    return c + CNT_W'(1);
  endfunction

  logic                          w_sclk_sync, w_sclk_rise;
  logic                          w_latch_sync, w_latch_rise;
  logic                          w_oe_sync, w_oe_rise;
  logic [ROW_COUNT-1:0]          w_row_sync, w_row_rise;
  logic                          w_unused;

  logic [LANES-1:0]              r_data_p0, r_data_p1;
  logic [LANES-1:0][BITS-1:0]    r_shreg;
  logic [LANES-1:0][BITS-1:0]    w_shreg_next;
  logic [CNT_W-1:0]              r_bit_count;
  logic [CNT_W-1:0]              w_cnt_shift;
  rx_state_t                     r_state, w_state_next;
  logic [ROW_IDX_W-1:0]          w_row_idx;
  logic                          w_row_err;

  sync_edge #(.WIDTH(1), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .reset(reset), .i_d(serial_clk),
    .o_sync(w_sclk_sync), .o_rise(w_sclk_rise)
  );

  sync_edge #(.WIDTH(1), .RESET_VAL(1'b0)) u_sync_latch (
    .clk(clk), .reset(reset), .i_d(latch_enable),
    .o_sync(w_latch_sync), .o_rise(w_latch_rise)
  );

  sync_edge #(.WIDTH(1), .RESET_VAL(1'b1)) u_sync_oe (
    .clk(clk), .reset(reset), .i_d(output_enable_n),
    .o_sync(w_oe_sync), .o_rise(w_oe_rise)
  );

  sync_edge #(.WIDTH(ROW_COUNT), .RESET_VAL({ROW_COUNT{1'b1}})) u_sync_row (
    .clk(clk), .reset(reset), .i_d(row_select_n),
    .o_sync(w_row_sync), .o_rise(w_row_rise)
  );

  // Level-only synchronizer outputs and edge outputs not needed here.
  assign w_unused = ^{w_sclk_sync, w_latch_sync, w_oe_rise, w_row_rise};

  // ---- p0/p1: data delayed two flops to stay aligned with synchronized serial_clk
  always_ff @(posedge clk) begin
    r_data_p0 <= serial_data_in;
    r_data_p1 <= r_data_p0;
  end

  // Shift every lane left on a serial clock rise; first bit ends as MSB.
  always_comb begin
    w_shreg_next = r_shreg;
    if (w_sclk_rise) begin
      for (int i = 0; i < LANES; i++) begin
        w_shreg_next[i] = {r_shreg[i][BITS-2:0], r_data_p1[i]};
      end
    end
  end

  // Lane shift registers; a stale partial row is harmless because the
  // shift counter, not the register contents, decides row validity.
  always_ff @(posedge clk) begin
    r_shreg <= w_shreg_next;
  end

  // Count as of this cycle's shift, so a coincident latch includes the bit.
  assign w_cnt_shift = w_sclk_rise ? sat_inc(r_bit_count) : r_bit_count;

  // Shift counter, cleared by each latch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bit_count <= '0;
    end else if (w_latch_rise) begin
      r_bit_count <= '0;
    end else begin
      r_bit_count <= w_cnt_shift;
    end
  end

  // Receiver state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state: shifting moves forward, any latch returns to idle.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE:     if (w_sclk_rise) w_state_next = ST_SHIFTING;
      ST_SHIFTING: if (w_sclk_rise && (w_cnt_shift == CNT_W'(BITS + 1))) w_state_next = ST_OVERRUN;
      ST_OVERRUN:  w_state_next = ST_OVERRUN;
      default:     w_state_next = ST_IDLE;
    endcase
    if (w_latch_rise) w_state_next = ST_IDLE;
  end

  // Row select decode at latch time.
  always_comb begin
    w_row_idx = '0;
    w_row_err = 1'b0;
`ifdef ROW_CHECK_EN
    if (active_count(w_row_sync) != ROW_CNT_W'(1)) begin
      w_row_err = 1'b1;
    end else begin
      w_row_idx = lowest_active(w_row_sync);
    end
`else
    w_row_idx = lowest_active(w_row_sync);
`endif
  end

  // ---- p2: latched row outputs, held until the next latch
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_data     <= '0;
      row_index    <= '0;
      length_error <= 1'b0;
      row_error    <= 1'b0;
      row_valid    <= 1'b0;
    end else begin
      row_valid <= w_latch_rise;
      if (w_latch_rise) begin
        row_data     <= w_shreg_next;
        row_index    <= w_row_idx;
        length_error <= (w_cnt_shift != CNT_W'(BITS));
        row_error    <= w_row_err;
      end
    end
  end

  assign blank = w_oe_sync;

endmodule

// File: tb/tb_panel_stream_receiver.sv
// Self-checking bench for panel_stream_receiver. Honours ROW_CHECK_EN the
// same way as the design when it is defined for the build.
module tb_panel_stream_receiver;

  localparam int LANES = 12;
  localparam int BITS  = 16;
  localparam int W     = LANES * BITS;

  logic             clk = 1'b0;
  logic             reset;
  logic             serial_clk;
  logic             latch_enable;
  logic             output_enable_n;
  logic [LANES-1:0] serial_data_in;
  logic [15:0]      row_select_n;
  logic [W-1:0]     row_data;
  logic [3:0]       row_index;
  logic             row_valid;
  logic             length_error;
  logic             row_error;
  logic             blank;

  always #5 clk = ~clk;

  panel_stream_receiver #(.LANES(LANES), .BITS(BITS)) dut (
    .clk(clk), .reset(reset), .serial_clk(serial_clk), .latch_enable(latch_enable),
    .output_enable_n(output_enable_n), .serial_data_in(serial_data_in),
    .row_select_n(row_select_n), .row_data(row_data), .row_index(row_index),
    .row_valid(row_valid), .length_error(length_error), .row_error(row_error),
    .blank(blank)
  );

  typedef struct {
    logic [W-1:0] data;
    logic [3:0]   idx;
    logic         len_err;
    logic         row_err;
    int           due;
  } exp_t;

  int               checks = 0;
  int               errors = 0;
  int               cyc = 0;
  int               n_valid = 0;
  int               last_valid_cyc = -1;
  int               latch_cyc = 0;
  int               row_cnt = 0;
  exp_t             pend[$];
  logic [LANES-1:0] hist[$];
  logic [31:0]      lane_w [LANES];

  task automatic chk(string name, logic [W-1:0] act, logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: a latched lane holds its most recent BITS shifted bits, newest at LSB.
  function automatic logic [W-1:0] model_row();
    logic [W-1:0] d;
    int n;
    d = '0;
    n = hist.size();
    for (int i = 0; i < LANES; i++) begin
      for (int j = 0; j < BITS; j++) begin
        if (n - 1 - j >= 0) d[i*BITS + j] = hist[n-1-j][i];
      end
    end
    return d;
  endfunction

  function automatic void model_rowsel(input logic [15:0] sel_n, output logic [3:0] idx,
                                       output logic err);
    int n;
    int first;
    n = 0;
    first = -1;
    for (int r = 0; r < 16; r++) begin
      if (!sel_n[r]) begin
        n++;
        if (first < 0) first = r;
      end
    end
`ifdef ROW_CHECK_EN
    err = (n != 1);
    idx = (n == 1) ? 4'(first) : 4'd0;
`else
    err = 1'b0;
    idx = (first < 0) ? 4'd0 : 4'(first);
`endif
  endfunction

  // Compare process: every cycle, #1 after the rising edge.
  initial begin
    exp_t held;
    logic [1:0] oe_hist;
    logic ev;
    held.data = '0; held.idx = '0; held.len_err = 1'b0; held.row_err = 1'b0; held.due = 0;
    oe_hist = 2'b11;
    forever begin
      @(posedge clk);
      cyc++;
      if (reset) oe_hist = 2'b11;
      else       oe_hist = {oe_hist[0], output_enable_n};
      #1;
      ev = (pend.size() > 0) && (pend[0].due == cyc);
      if (reset) begin
        held.data = '0; held.idx = '0; held.len_err = 1'b0; held.row_err = 1'b0;
      end
      if (ev) begin
        held = pend.pop_front();
        n_valid++;
        last_valid_cyc = cyc;
      end
      chk("row_valid", W'(row_valid), W'(ev));
      chk("row_data", row_data, held.data);
      chk("row_index", W'(row_index), W'(held.idx));
      chk("length_error", W'(length_error), W'(held.len_err));
      chk("row_error", W'(row_error), W'(held.row_err));
      chk("blank", W'(blank), W'(oe_hist[1]));
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [LANES-1:0] bits_at(int pos);
    logic [LANES-1:0] b;
    for (int i = 0; i < LANES; i++) b[i] = lane_w[i][pos];
    return b;
  endfunction

  task automatic push_expect();
    exp_t e;
    e.data    = model_row();
    model_rowsel(row_select_n, e.idx, e.row_err);
    e.len_err = (row_cnt != BITS);
    e.due     = cyc + 3;
    pend.push_back(e);
    row_cnt   = 0;
    latch_cyc = cyc;
  endtask

  task automatic shift1(logic [LANES-1:0] bits);
    serial_data_in = bits;
    tick(4);
    serial_clk = 1'b1;
    hist.push_back(bits);
    row_cnt++;
    tick(4);
    serial_clk = 1'b0;
  endtask

  task automatic send_row(int n);
    for (int k = 0; k < n; k++) shift1(bits_at(n - 1 - k));
  endtask

  task automatic latch_row();
    latch_enable = 1'b1;
    push_expect();
    tick(4);
    latch_enable = 1'b0;
    tick(4);
  endtask

  // Last shift and latch strobe rise together.
  task automatic shift_and_latch(logic [LANES-1:0] bits);
    serial_data_in = bits;
    tick(4);
    serial_clk   = 1'b1;
    latch_enable = 1'b1;
    hist.push_back(bits);
    row_cnt++;
    push_expect();
    tick(4);
    serial_clk   = 1'b0;
    latch_enable = 1'b0;
    tick(4);
  endtask

  task automatic set_lanes(logic [31:0] seed);
    for (int i = 0; i < LANES; i++) lane_w[i] = 32'(i) * 32'h9E37 + seed;
  endtask

  // Outputs after a latch: pulse count, latency, and flags.
  task automatic chk_latch(string tag, logic exp_len, logic exp_rerr, logic [3:0] exp_idx);
    chk({tag, "_pulses"}, W'(n_valid), W'(1));
    chk({tag, "_latency"}, W'(last_valid_cyc - latch_cyc), W'(3));
    chk({tag, "_len"}, W'(length_error), W'(exp_len));
    chk({tag, "_rerr"}, W'(row_error), W'(exp_rerr));
    chk({tag, "_idx"}, W'(row_index), W'(exp_idx));
    n_valid = 0;
  endtask

  initial begin
    reset = 1'b1;
    serial_clk = 1'b0; latch_enable = 1'b0; output_enable_n = 1'b1;
    serial_data_in = '0; row_select_n = 16'hFFFF;

    // Reset with random inputs.
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      serial_clk = 1'($urandom); latch_enable = 1'($urandom);
      output_enable_n = 1'($urandom); row_select_n = 16'($urandom);
      serial_data_in = LANES'($urandom);
    end
    @(negedge clk);
    chk("rst_row_data", row_data, '0);
    chk("rst_row_valid", W'(row_valid), W'(0));
    chk("rst_blank", W'(blank), W'(1));
    chk("rst_flags", W'({length_error, row_error, row_index}), W'(0));
    serial_clk = 1'b0; latch_enable = 1'b0; output_enable_n = 1'b1; row_select_n = 16'hFFFF;
    tick(2);
    reset = 1'b0;
    tick(3);

    // Nominal row.
    row_select_n = 16'hFFF7;
    set_lanes(32'h0000_1234);
    lane_w[0]  = 32'h0000_A5C3;
    lane_w[11] = 32'h0000_0FF0;
    send_row(16);
    latch_row();
    chk_latch("nominal", 1'b0, 1'b0, 4'd3);
    chk("nominal_lane0", W'(row_data[15:0]), W'(16'hA5C3));
    chk("nominal_lane11", W'(row_data[11*BITS +: BITS]), W'(16'h0FF0));

    // Blanking follows output_enable_n.
    output_enable_n = 1'b0;
    tick(3);
    chk("blank_low", W'(blank), W'(0));
    output_enable_n = 1'b1;
    tick(3);
    chk("blank_high", W'(blank), W'(1));

    // Short row.
    row_select_n = 16'hFFFE;
    set_lanes(32'h0000_7ABC);
    send_row(15);
    latch_row();
    chk_latch("short", 1'b1, 1'b0, 4'd0);

    // Long row: only the last 16 bits survive.
    row_select_n = 16'h7FFF;
    set_lanes(32'h0002_0F0F);
    lane_w[0] = 32'h0002_BEEF;
    send_row(18);
    latch_row();
    chk_latch("long", 1'b1, 1'b0, 4'd15);
    chk("long_lane0", W'(row_data[15:0]), W'(16'hBEEF));

    // Coincident 16th shift and latch.
    row_select_n = 16'hFFDF;
    set_lanes(32'h0000_5555);
    lane_w[0] = 32'h0000_8001;
    for (int k = 0; k < 15; k++) shift1(bits_at(15 - k));
    shift_and_latch(bits_at(0));
    chk_latch("coincident", 1'b0, 1'b0, 4'd5);
    chk("coincident_lane0", W'(row_data[15:0]), W'(16'h8001));

    // Row select with two rows active.
    row_select_n = 16'hFFF3;
    set_lanes(32'h0000_C0DE);
    send_row(16);
    latch_row();
`ifdef ROW_CHECK_EN
    chk_latch("rowchk", 1'b0, 1'b1, 4'd0);
`else
    chk_latch("rowchk", 1'b0, 1'b0, 4'd2);
`endif

    // Reset in the middle of a row.
    row_select_n = 16'hFFFE;
    set_lanes(32'h0000_FFFF);
    send_row(8);
    reset = 1'b1;
    pend.delete();
    row_cnt = 0;
    tick(3);
    chk("midrst_row_data", row_data, '0);
    reset = 1'b0;
    tick(3);
    set_lanes(32'h0000_0101);
    lane_w[0] = 32'h0000_3C5A;
    send_row(16);
    latch_row();
    chk_latch("midrst", 1'b0, 1'b0, 4'd0);
    chk("midrst_lane0", W'(row_data[15:0]), W'(16'h3C5A));

    tick(5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
